// File: rtl/id_stage_buf.sv
// rtl/id_stage_buf.sv - RV32I decode stage feeding a DEPTH-entry FIFO of decoded bundles.
// Optional macro ID_STAGE_CSR_EN enables decode of SYSTEM (opcode 1110011) as type 7.
module id_stage_buf #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic [XLEN-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [4:0]               out_rd,
   output logic [6:0]               out_opcode,
   output logic [2:0]               out_func3,
   output logic [6:0]               out_func7,
   output logic [XLEN-1:0]          out_imm,
   output logic [3:0]               out_alu_op,
   output logic [2:0]               out_type,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   cnt;
   logic            push, pop;

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];
   logic [XLEN-1:0] imm_mem  [DEPTH];
   logic [3:0]      alu_mem  [DEPTH];
   logic [2:0]      type_mem [DEPTH];
   logic            ill_mem  [DEPTH];

   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [31:0]     imm32;
   logic [XLEN-1:0] d_imm;
   logic [3:0]      d_alu;
   logic [2:0]      d_type;
   logic            d_ill;

   assign opcode = in_inst[6:0];
   assign func3  = in_inst[14:12];

   // imm32 is built as a 32-bit value whose bit 31 already carries the sign,
   // so a single signed widening covers both sign- and zero-extended forms.
   always_comb begin
      imm32  = '0;
      d_alu  = 4'b0000;
      d_type = 3'd0;
      d_ill  = 1'b1;
      case (opcode)
         7'b0110011: begin
            d_type = 3'd1;
            d_ill  = 1'b0;
            d_alu  = {in_inst[30], func3};
         end
         7'b0010011: begin
            d_type = 3'd2;
            d_ill  = 1'b0;
            if (func3 == 3'b001 || func3 == 3'b101)
               imm32 = {27'b0, in_inst[24:20]};
            else
               imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            d_alu  = (func3 == 3'b101) ? {in_inst[30], func3} : {1'b0, func3};
         end
         7'b0000011, 7'b1100111: begin
            d_type = 3'd2;
            d_ill  = 1'b0;
            imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         7'b0110111, 7'b0010111: begin
            d_type = 3'd3;
            d_ill  = 1'b0;
            imm32  = {in_inst[31:12], 12'b0};
         end
         7'b0100011: begin
            d_type = 3'd4;
            d_ill  = 1'b0;
            imm32  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         7'b1100011: begin
            d_type = 3'd5;
            d_ill  = 1'b0;
            imm32  = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         end
         7'b1101111: begin
            d_type = 3'd6;
            d_ill  = 1'b0;
            imm32  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         end
`ifdef ID_STAGE_CSR_EN
         7'b1110011: begin
            d_type = 3'd7;
            d_ill  = 1'b0;
            imm32  = func3[2] ? {27'b0, in_inst[19:15]} : {20'b0, in_inst[31:20]};
         end
`else
`endif
         default: ;
      endcase
      d_imm = XLEN'($signed(imm32));
   end

   assign in_ready  = rst_n & (cnt < CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= in_pc;
         inst_mem[wr_ptr] <= in_inst;
         imm_mem[wr_ptr]  <= d_imm;
         alu_mem[wr_ptr]  <= d_alu;
         type_mem[wr_ptr] <= d_type;
         ill_mem[wr_ptr]  <= d_ill;
      end
   end

   // Register fields come straight from the stored word; all outputs read 0 when empty.
   always_comb begin
      out_pc      = '0;
      out_rs1     = '0;
      out_rs2     = '0;
      out_rd      = '0;
      out_opcode  = '0;
      out_func3   = '0;
      out_func7   = '0;
      out_imm     = '0;
      out_alu_op  = '0;
      out_type    = '0;
      out_illegal = 1'b0;
      if (out_valid) begin
         out_pc      = pc_mem[rd_ptr];
         out_rs1     = inst_mem[rd_ptr][19:15];
         out_rs2     = inst_mem[rd_ptr][24:20];
         out_rd      = inst_mem[rd_ptr][11:7];
         out_opcode  = inst_mem[rd_ptr][6:0];
         out_func3   = inst_mem[rd_ptr][14:12];
         out_func7   = inst_mem[rd_ptr][31:25];
         out_imm     = imm_mem[rd_ptr];
         out_alu_op  = alu_mem[rd_ptr];
         out_type    = type_mem[rd_ptr];
         out_illegal = ill_mem[rd_ptr];
      end
   end
endmodule

// File: tb/tb_id_stage_buf.sv
// tb/tb_id_stage_buf.sv - scoreboard bench for id_stage_buf with a queue-based reference model.
module tb_id_stage_buf;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0]       in_inst = '0;
   logic [XLEN-1:0]   in_pc = '0;
   logic              in_ready, out_valid, out_illegal;
   logic [XLEN-1:0]   out_pc, out_imm;
   logic [4:0]        out_rs1, out_rs2, out_rd;
   logic [6:0]        out_opcode, out_func7;
   logic [2:0]        out_func3, out_type;
   logic [3:0]        out_alu_op;
   logic [$clog2(DEPTH):0] count;

   int tests = 0;
   int failed = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  opcode, func7;
      logic [2:0]  func3;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [2:0]  typ;
      logic        ill;
   } bundle_t;

   bundle_t q[$];

   id_stage_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
      .out_imm(out_imm), .out_alu_op(out_alu_op), .out_type(out_type),
      .out_illegal(out_illegal), .count(count)
   );

   always #5 clk = ~clk;

   function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      bundle_t b;
      int      imm;
      b.pc = pc;
      b.rs1 = i[19:15];
      b.rs2 = i[24:20];
      b.rd = i[11:7];
      b.opcode = i[6:0];
      b.func3 = i[14:12];
      b.func7 = i[31:25];
      imm = 0;
      b.alu = 4'd0;
      b.typ = 3'd0;
      b.ill = 1'b1;
      case (i[6:0])
         7'h33: begin b.typ = 1; b.ill = 0; b.alu = {i[30], i[14:12]}; end
         7'h13: begin
            b.typ = 2; b.ill = 0;
            if (i[14:12] == 3'd1 || i[14:12] == 3'd5) imm = int'(i[24:20]);
            else imm = $signed(i[31:20]);
            b.alu = (i[14:12] == 3'd5) ? {i[30], i[14:12]} : {1'b0, i[14:12]};
         end
         7'h03, 7'h67: begin b.typ = 2; b.ill = 0; imm = $signed(i[31:20]); end
         7'h37, 7'h17: begin b.typ = 3; b.ill = 0; imm = {i[31:12], 12'h000}; end
         7'h23: begin b.typ = 4; b.ill = 0; imm = $signed({i[31:25], i[11:7]}); end
         7'h63: begin b.typ = 5; b.ill = 0; imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
         7'h6F: begin b.typ = 6; b.ill = 0; imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
`ifdef ID_STAGE_CSR_EN
         7'h73: begin b.typ = 7; b.ill = 0; imm = i[14] ? int'(i[19:15]) : int'(i[31:20]); end
`endif
         default: ;
      endcase
      b.imm = imm;
      return b;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17,
                                7'h23, 7'h63, 7'h6F, 7'h73, 7'h13};
      logic [31:0] r;
      int          sel;
      r = $urandom;
      sel = $urandom_range(0, 13);
      if (sel < 11) r[6:0] = ops[sel];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected bundles enter the queue as stimulus is accepted.
   always @(posedge clk) begin
      bit do_push, do_pop;
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = (q.size() > 0) && out_ready;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(ref_decode(in_inst, in_pc));
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("count", 64'(count), 64'(q.size()));
         check("in_ready", 64'(in_ready), 64'(rst_n && q.size() < DEPTH));
         check("out_valid", 64'(out_valid), 64'(q.size() != 0));
         if (q.size() > 0) begin
            check("out_pc", 64'(out_pc), 64'(q[0].pc));
            check("out_rs1", 64'(out_rs1), 64'(q[0].rs1));
            check("out_rs2", 64'(out_rs2), 64'(q[0].rs2));
            check("out_rd", 64'(out_rd), 64'(q[0].rd));
            check("out_opcode", 64'(out_opcode), 64'(q[0].opcode));
            check("out_func3", 64'(out_func3), 64'(q[0].func3));
            check("out_func7", 64'(out_func7), 64'(q[0].func7));
            check("out_imm", 64'(out_imm), 64'(q[0].imm));
            check("out_alu_op", 64'(out_alu_op), 64'(q[0].alu));
            check("out_type", 64'(out_type), 64'(q[0].typ));
            check("out_illegal", 64'(out_illegal), 64'(q[0].ill));
         end else begin
            check("empty_data", 64'({out_pc, out_rs1, out_rs2, out_rd, out_opcode, out_func3}), 64'd0);
            check("empty_data2", 64'({out_func7, out_imm, out_alu_op, out_type, out_illegal}), 64'd0);
         end
      end
   end

   task automatic step(input logic r, input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic rdy, input logic fl);
      rst_n = r; in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pc;
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 32'hFFB10093, 0, 0, 0);
      mon_en = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      // addi, srai, beq
      step(1, 1, 32'hFFB10093, 32'h100, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 1, 32'h40725193, 32'h104, 1, 0);
      step(1, 1, 32'hFE208CE3, 32'h108, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      // Three pushes into DEPTH=2 with out_ready low, then drain
      step(1, 1, 32'h00000013, 32'h0, 0, 0);
      step(1, 1, 32'h00100093, 32'h4, 0, 0);
      step(1, 1, 32'h00200113, 32'h8, 0, 0);
      step(1, 1, 32'h00200113, 32'h8, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      // Full with pop and push offered: pop only
      step(1, 1, 32'h00000013, 32'h10, 0, 0);
      step(1, 1, 32'h00000013, 32'h14, 0, 0);
      step(1, 1, 32'h00000013, 32'h18, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      // Flush with push offered
      step(1, 1, 32'h00000013, 32'h20, 0, 0);
      step(1, 1, 32'h00000013, 32'h24, 0, 0);
      step(1, 1, 32'h00000013, 32'h28, 1, 1);
      step(1, 0, 0, 0, 1, 0);
      // Illegal zero word and CSR immediate form
      step(1, 1, 32'h00000000, 32'h30, 0, 0);
      step(1, 1, 32'h3002D073, 32'h34, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      // Reset mid-stream
      step(1, 1, 32'h00000013, 32'h40, 0, 0);
      step(0, 1, 32'h00000013, 32'h44, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // Random traffic
      pc = 32'h1000;
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, rand_inst(), pc,
              $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
         pc += 4;
      end
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
